mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative HI/LO multiply/divide unit for the EX stage of the pipelined MIPS core. It consumes the two operands read from the register file (rs on A, rt on B) and computes MULT, MULTU, DIV and DIVU over 33 cycles, holding the result in architectural HI/LO registers. Busy feeds the hazard unit so that dependent MFHI/MFLO/MTHI/MTLO and further mult/div instructions stall. It also serves MTHI/MTLO writes.

## Interface
- No parameters; datapath fixed at 32 bits.
- Clk  input  1  clock; all state updates on posedge
- Rst  input  1  synchronous, active-high reset
- Start  input  1  launch operation; sampled only in IDLE
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  32  operand rs (multiplicand / dividend)
- B  input  32  operand rt (multiplier / divisor)
- HiWr  input  1  MTHI: Hi <= WrData; honoured only when not Busy
- LoWr  input  1  MTLO: Lo <= WrData; honoured only when not Busy
- WrData  input  32  MTHI/MTLO data
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse; Hi/Lo were updated at the previous edge
- Hi  output  32  HI register (product high word / remainder)
- Lo  output  32  LO register (product low word / quotient)

## Operation
- States: IDLE, CALC, FIX. A 5-bit iteration counter runs only in CALC.
- IDLE with Start=1: capture Op, sign flags, |A|, |B| and the div-by-zero flag (DIV/DIVU with B==0). Set Busy=1. Go to CALC with counter=0.
  - Magnitudes are taken only for signed ops (MULT, DIV).
- CALC, multiply: radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle. Remainder register is 33 bits.
- CALC runs 32 iterations. After counter==31, go to FIX.
- FIX applies signs:
  - Product negated when sign(A)^sign(B) (MULT only).
  - Quotient negated when sign(A)^sign(B); remainder takes sign(A) (DIV only).
  - Writes Hi/Lo, sets Done=1, Busy=0, returns to IDLE.
- Divide by zero, signed or unsigned, completes with the same latency: Lo=0xFFFFFFFF, Hi=A as captured.
- DIV 0x80000000 / 0xFFFFFFFF yields Lo=0x80000000, Hi=0. This is the natural two's-complement wrap; no trap.
- Start while Busy is ignored; it is not queued.
- HiWr/LoWr while Busy are ignored. The hazard unit guarantees they do not occur.
- HiWr/LoWr and Start in the same IDLE edge: both take effect. Hi/Lo get WrData now and are overwritten at completion.
- Start in the Done cycle: accepted, because the state is IDLE.
- Operand inputs may change freely after the Start edge.

## Timing
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, state IDLE, counter 0.
- Rst mid-operation aborts. Hi/Lo are cleared and no Done pulse is produced.
- Start accepted at edge E0:
  - Busy=1 from after E0 through E33.
  - CALC iterations occur at E1..E32.
  - FIX occurs at E33: Hi/Lo valid after E33, Busy=0, Done=1 for exactly one cycle (E33 to E34).
- Latency is 33 cycles from the accepting edge to the result, independent of Op and operand values.
- Back-to-back: the next Start is accepted at E33+1 at the earliest, i.e. the Done cycle.
- MTHI/MTLO: Hi/Lo updated at the edge where HiWr/LoWr is sampled. Visible the following cycle.
- Busy and Done are registered outputs; no combinational input-to-output paths.

## Test plan
- Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Busy for 33 cycles, Done one cycle, Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=-3 B=5, then DIV A=-7 B=2 -> Hi=0xFFFFFFFF Lo=0xFFFFFFF1; then Lo=0xFFFFFFFD (-3) Hi=0xFFFFFFFF (-1).
- DIVU 100/7 -> Lo=14 Hi=2. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000 Hi=0. DIVU 0x1234/0 -> Lo=0xFFFFFFFF Hi=0x1234.
- Start pulsed again at cycle 10 of a MULT, plus HiWr during Busy -> both ignored. The original result lands at E33; Start re-asserted in the Done cycle is accepted.
- Rst asserted at cycle 20 of a DIV -> next cycle Busy=0, Hi=Lo=0, no Done pulse. A new operation after Rst completes correctly.
- Idle HiWr WrData=0xCAFEF00D, then LoWr WrData=0x12345678 -> Hi/Lo update one edge each. HiWr together with Start -> Hi briefly 0xCAFEF00D, then the result.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// MULT/MULTU run a radix-2 shift-add loop over a 64-bit accumulator. DIV/DIVU
// run a restoring shift-subtract loop with a 33-bit partial remainder. Both
// loops work on operand magnitudes and take 32 iterations. Signs are applied
// in one final cycle, so every operation has the same 33-cycle latency.
module mult_div_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiWr,
    input  logic        LoWr,
    input  logic [31:0] WrData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      stateNext_s;
    logic        busyNext_s;
    logic        doneNext_s;
    logic [4:0]  count_r;

    // Captured operation context
    logic        isDiv_r;
    logic        signA_r;
    logic        signB_r;
    logic        divZero_r;

    // Iteration datapath: hiAcc_r is the product high word or the partial
    // remainder; loAcc_r is the multiplier (shifted out) or the dividend
    // (shifted out) that becomes the quotient; opnd_r is |multiplicand| or
    // |divisor|.
    logic [32:0] hiAcc_r;
    logic [31:0] loAcc_r;
    logic [31:0] opnd_r;

    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    // Operand magnitudes: only the signed ops (Op[0]==0) take the absolute value.
    logic        signA_s;
    logic        signB_s;
    logic [31:0] absA_s;
    logic [31:0] absB_s;

    assign signA_s = ~Op[0] & A[31];
    assign signB_s = ~Op[0] & B[31];
    assign absA_s  = signA_s ? (32'd0 - A) : A;
    assign absB_s  = signB_s ? (32'd0 - B) : B;

    // One multiply step: add the multiplicand when the current multiplier
    // bit is set. Shifting right by one happens when the sum is stored.
    logic [31:0] mulAdd_s;
    logic [32:0] mulSum_s;

    assign mulAdd_s = loAcc_r[0] ? opnd_r : 32'd0;
    assign mulSum_s = {1'b0, hiAcc_r[31:0]} + {1'b0, mulAdd_s};

    // One divide step: shift the next dividend bit into the remainder, then
    // trial-subtract the divisor. A negative result restores the remainder.
    logic [33:0] divShift_s;
    logic [33:0] divDiff_s;

    assign divShift_s = {hiAcc_r, loAcc_r[31]};
    assign divDiff_s  = divShift_s - {2'b00, opnd_r};

    // Sign fix-up. Unsigned ops captured zero sign flags, so they pass through.
    logic [63:0] product_s;
    logic [63:0] productFix_s;
    logic [31:0] quotFix_s;
    logic [31:0] remFix_s;

    assign product_s    = {hiAcc_r[31:0], loAcc_r};
    assign productFix_s = (signA_r ^ signB_r) ? (64'd0 - product_s) : product_s;
    assign quotFix_s    = (signA_r ^ signB_r) ? (32'd0 - loAcc_r) : loAcc_r;
    assign remFix_s     = signA_r ? (32'd0 - hiAcc_r[31:0]) : hiAcc_r[31:0];

    // Next-state and registered-output values for the control FSM.
    always_comb begin
        stateNext_s = state_r;
        busyNext_s  = busy_r;
        doneNext_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    stateNext_s = CALC;
                    busyNext_s  = 1'b1;
                end else begin
                    stateNext_s = IDLE;
                    busyNext_s  = 1'b0;
                end
            end
            CALC: begin
                busyNext_s = 1'b1;
                if (count_r == 5'd31) begin
                    stateNext_s = FIX;
                end else begin
                    stateNext_s = CALC;
                end
            end
            FIX: begin
                stateNext_s = IDLE;
                busyNext_s  = 1'b0;
                doneNext_s  = 1'b1;
            end
            default: begin
                stateNext_s = IDLE;
                busyNext_s  = 1'b0;
            end
        endcase
    end

    // FSM state plus the Busy/Done output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= stateNext_s;
            busy_r  <= busyNext_s;
            done_r  <= doneNext_s;
        end
    end

    // Datapath: operand capture, iteration, sign fix-up and MTHI/MTLO writes.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_r   <= 5'd0;
            isDiv_r   <= 1'b0;
            signA_r   <= 1'b0;
            signB_r   <= 1'b0;
            divZero_r <= 1'b0;
            hiAcc_r   <= 33'd0;
            loAcc_r   <= 32'd0;
            opnd_r    <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (HiWr) begin
                        hi_r <= WrData;
                    end
                    if (LoWr) begin
                        lo_r <= WrData;
                    end
                    if (Start) begin
                        count_r   <= 5'd0;
                        isDiv_r   <= Op[1];
                        signA_r   <= signA_s;
                        signB_r   <= signB_s;
                        divZero_r <= Op[1] & (B == 32'd0);
                        hiAcc_r   <= 33'd0;
                        if (Op[1]) begin
                            loAcc_r <= absA_s;
                            opnd_r  <= absB_s;
                        end else begin
                            loAcc_r <= absB_s;
                            opnd_r  <= absA_s;
                        end
                    end
                end
                CALC: begin
                    count_r <= count_r + 5'd1;
                    if (isDiv_r) begin
                        if (divDiff_s[33]) begin
                            hiAcc_r <= divShift_s[32:0];
                            loAcc_r <= {loAcc_r[30:0], 1'b0};
                        end else begin
                            hiAcc_r <= divDiff_s[32:0];
                            loAcc_r <= {loAcc_r[30:0], 1'b1};
                        end
                    end else begin
                        hiAcc_r <= {1'b0, mulSum_s[32:1]};
                        loAcc_r <= {mulSum_s[0], loAcc_r[31:1]};
                    end
                end
                FIX: begin
                    if (isDiv_r) begin
                        // A zero divisor leaves the dividend as the remainder,
                        // so the ordinary sign rule already yields Hi=A.
                        hi_r <= remFix_s;
                        lo_r <= divZero_r ? 32'hFFFF_FFFF : quotFix_s;
                    end else begin
                        hi_r <= productFix_s[63:32];
                        lo_r <= productFix_s[31:0];
                    end
                end
                default: begin
                    count_r <= 5'd0;
                end
            endcase
        end
    end

    assign Busy = busy_r;
    assign Done = done_r;
    assign Hi   = hi_r;
    assign Lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiWr;
    logic        LoWr;
    logic [31:0] WrData;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int checks;
    int passes;
    logic [31:0] expHi;
    logic [31:0] expLo;

    mult_div_unit dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .HiWr   (HiWr),
        .LoWr   (LoWr),
        .WrData (WrData),
        .Busy   (Busy),
        .Done   (Done),
        .Hi     (Hi),
        .Lo     (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: MIPS HI/LO semantics computed with plain integer arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        case (op)
            2'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Launch one op from IDLE and check Busy window, latency, Done and result.
    // Returns just after E33 (the Done cycle). disturbAt>0 pulses Start/HiWr/LoWr
    // that many cycles into the operation; wrWithStart issues MTHI with Start.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int disturbAt, input logic wrWithStart, input string name);
        logic [63:0] exp;
        int busyBad;
        exp = refModel(op, a, b);
        Start = 1'b1; Op = op; A = a; B = b;
        if (wrWithStart) begin
            HiWr = 1'b1;
            WrData = 32'hCAFE_F00D;
        end
        @(posedge Clk); #1;
        Start = 1'b0; HiWr = 1'b0; LoWr = 1'b0;
        A = $urandom; B = $urandom; Op = 2'($urandom);
        if (wrWithStart) begin
            checks++;
            if (Hi !== 32'hCAFE_F00D) $display("FAIL %s hi_with_start: got %h want cafef00d", name, Hi);
            else passes++;
        end
        busyBad = 0;
        for (int k = 0; k <= 32; k++) begin
            if (!(Busy === 1'b1 && Done === 1'b0)) busyBad++;
            if (k == disturbAt) begin
                Start = 1'b1; HiWr = 1'b1; LoWr = 1'b1; WrData = $urandom; Op = 2'($urandom);
            end else begin
                Start = 1'b0; HiWr = 1'b0; LoWr = 1'b0;
            end
            @(posedge Clk); #1;
        end
        checks++;
        if (busyBad != 0) $display("FAIL %s busy_window: %0d bad cycles, want 0", name, busyBad);
        else passes++;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b1) $display("FAIL %s done_at_E33: busy=%b done=%b want busy=0 done=1", name, Busy, Done);
        else passes++;
        checks++;
        if (Hi !== exp[63:32]) $display("FAIL %s hi: op=%0d a=%h b=%h got %h want %h", name, op, a, b, Hi, exp[63:32]);
        else passes++;
        checks++;
        if (Lo !== exp[31:0]) $display("FAIL %s lo: op=%0d a=%h b=%h got %h want %h", name, op, a, b, Lo, exp[31:0]);
        else passes++;
        expHi = exp[63:32];
        expLo = exp[31:0];
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0)
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", Busy, Done, Hi, Lo);
        else passes++;
        expHi = 32'd0;
        expLo = 32'd0;
    endtask

    task automatic test_multu_max;
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, "multu_max");
        checks++;
        if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) $display("FAIL multu_max_const: got %h_%h want fffffffe_00000001", Hi, Lo);
        else passes++;
        @(posedge Clk); #1;
        checks++;
        if (Done !== 1'b0) $display("FAIL done_pulse_width: done=%b want 0", Done);
        else passes++;
    endtask

    task automatic test_signed;
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, -1, 1'b0, "mult_neg");
        checks++;
        if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFF1) $display("FAIL mult_neg_const: got %h_%h want ffffffff_fffffff1", Hi, Lo);
        else passes++;
        @(posedge Clk); #1;
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, "div_neg");
        checks++;
        if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_const: got %h_%h want ffffffff_fffffffd", Hi, Lo);
        else passes++;
        @(posedge Clk); #1;
    endtask

    task automatic test_div_corners;
        run_op(2'd3, 32'd100, 32'd7, -1, 1'b0, "divu_100_7");
        checks++;
        if (Hi !== 32'd2 || Lo !== 32'd14) $display("FAIL divu_const: got %h_%h want 00000002_0000000e", Hi, Lo);
        else passes++;
        @(posedge Clk); #1;
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, "div_wrap");
        checks++;
        if (Hi !== 32'd0 || Lo !== 32'h8000_0000) $display("FAIL div_wrap_const: got %h_%h want 00000000_80000000", Hi, Lo);
        else passes++;
        @(posedge Clk); #1;
        run_op(2'd3, 32'h0000_1234, 32'd0, -1, 1'b0, "divu_zero");
        checks++;
        if (Hi !== 32'h0000_1234 || Lo !== 32'hFFFF_FFFF) $display("FAIL divu_zero_const: got %h_%h want 00001234_ffffffff", Hi, Lo);
        else passes++;
        @(posedge Clk); #1;
        run_op(2'd2, 32'hFFFF_FF00, 32'd0, -1, 1'b0, "div_zero_signed");
        @(posedge Clk); #1;
    endtask

    task automatic test_busy_ignore_back_to_back;
        run_op(2'd0, $urandom, $urandom, 10, 1'b0, "busy_ignore");
        // Start in the Done cycle must be accepted immediately.
        run_op(2'd3, $urandom, 32'd13, -1, 1'b0, "back_to_back");
        @(posedge Clk); #1;
    endtask

    task automatic test_rst_abort;
        int doneSeen;
        Start = 1'b1; Op = 2'd2; A = $urandom; B = 32'd3;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (19) @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0)
            $display("FAIL rst_abort: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", Busy, Done, Hi, Lo);
        else passes++;
        doneSeen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge Clk); #1;
            if (Done === 1'b1 || Busy === 1'b1) doneSeen++;
        end
        checks++;
        if (doneSeen != 0) $display("FAIL rst_no_done: %0d cycles with busy/done, want 0", doneSeen);
        else passes++;
        run_op(2'd1, $urandom, $urandom, -1, 1'b0, "after_rst");
        @(posedge Clk); #1;
    endtask

    task automatic test_mthi_mtlo;
        HiWr = 1'b1; WrData = 32'hCAFE_F00D;
        @(posedge Clk); #1;
        HiWr = 1'b0;
        checks++;
        if (Hi !== 32'hCAFE_F00D || Lo !== expLo) $display("FAIL mthi: got %h_%h want cafef00d_%h", Hi, Lo, expLo);
        else passes++;
        LoWr = 1'b1; WrData = 32'h1234_5678;
        @(posedge Clk); #1;
        LoWr = 1'b0;
        checks++;
        if (Hi !== 32'hCAFE_F00D || Lo !== 32'h1234_5678) $display("FAIL mtlo: got %h_%h want cafef00d_12345678", Hi, Lo);
        else passes++;
        run_op(2'd1, $urandom, $urandom, -1, 1'b1, "hiwr_with_start");
        @(posedge Clk); #1;
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int n = 0; n < 16; n++) begin
            op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(3, 0) == 0) b = $urandom_range(15, 0);
            if ($urandom_range(3, 0) == 0) a = $urandom_range(255, 0);
            run_op(op, a, b, -1, 1'b0, "random");
            if (n[0]) begin
                @(posedge Clk); #1;
            end
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        passes = 0;
        Rst = 1'b0; Start = 1'b0; Op = 2'd0; A = 32'd0; B = 32'd0;
        HiWr = 1'b0; LoWr = 1'b0; WrData = 32'd0;
        expHi = 32'd0; expLo = 32'd0;
        #2;
        test_reset();
        test_multu_max();
        test_signed();
        test_div_corners();
        test_busy_ignore_back_to_back();
        test_rst_abort();
        test_mthi_mtlo();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
